// File: rtl/ps2_rx_pkg.sv
// Shared constants and state type for the PS/2 device-to-host receiver.
// Optional parity checking in the top is enabled with PS2_PARITY_CHECK_EN.
package ps2_rx_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  localparam int PS2_FILTER_LEN_DEF  = 8;
  localparam int PS2_TIMEOUT_CYC_DEF = 50000;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus glitch filter for one raw PS/2 pin.
// The filtered level only moves after FILTER_LEN consecutive differing samples.
module ps2_line_filter
  import ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    fall_d  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
      fall_d  = level_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Idle bus level is high, so everything resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: deserialises frames, folds E0/F0 prefixes into flags.
// Define PS2_PARITY_CHECK_EN to drop odd-parity failures and expose parity_err.
module ps2_frame_receiver
  import ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN  = PS2_FILTER_LEN_DEF,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_rcv,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       kb_interrupt,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
`ifdef PS2_PARITY_CHECK_EN
  output logic       parity_err,
`endif
  output logic       rx_busy
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYC);

  logic fclk_level_unused, data_fall_unused;
  logic sample, fdata;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2clk_in),
    .level   (fclk_level_unused),
    .fall    (sample)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2data_in),
    .level   (fdata),
    .fall    (data_fall_unused)
  );

  ps2_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] wd_q, wd_d;
  logic        ext_pend_q, ext_pend_d;
  logic        rel_pend_q, rel_pend_d;
  logic [7:0]  scancode_q, scancode_d;
  logic        extended_q, extended_d;
  logic        released_q, released_d;
  logic        kb_int_q, kb_int_d;
  logic        stop_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic        parity_q, parity_d;
  logic        parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    wd_d       = wd_q;
    ext_pend_d = ext_pend_q;
    rel_pend_d = rel_pend_q;
    scancode_d = scancode_q;
    extended_d = extended_q;
    released_d = released_q;
    kb_int_d   = 1'b0;
    stop_ok    = fdata;
`ifdef PS2_PARITY_CHECK_EN
    parity_d     = parity_q;
    parity_err_d = 1'b0;
`endif
    if (!enable_rcv) begin
      state_d    = IDLE;
      cnt_d      = '0;
      wd_d       = '0;
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
    end else if (sample) begin
      // A sample event always reloads the watchdog, even if it was about to expire.
      wd_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!fdata) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = {fdata, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d = fdata;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
`ifdef PS2_PARITY_CHECK_EN
          if (fdata && ((^shift_q ^ parity_q) != 1'b1)) begin
            stop_ok      = 1'b0;
            parity_err_d = 1'b1;
          end
`endif
          if (stop_ok && shift_q == PS2_PREFIX_EXT) begin
            ext_pend_d = 1'b1;
          end else if (stop_ok && shift_q == PS2_PREFIX_REL) begin
            rel_pend_d = 1'b1;
          end else begin
            if (stop_ok) begin
              scancode_d = shift_q;
              extended_d = ext_pend_q;
              released_d = rel_pend_q;
              kb_int_d   = 1'b1;
            end
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (wd_q + 16'd1 == TIMEOUT_W) begin
        state_d    = IDLE;
        wd_d       = '0;
        ext_pend_d = 1'b0;
        rel_pend_d = 1'b0;
      end else begin
        wd_d = wd_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      wd_q       <= '0;
      ext_pend_q <= 1'b0;
      rel_pend_q <= 1'b0;
      scancode_q <= '0;
      extended_q <= 1'b0;
      released_q <= 1'b0;
      kb_int_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      wd_q       <= wd_d;
      ext_pend_q <= ext_pend_d;
      rel_pend_q <= rel_pend_d;
      scancode_q <= scancode_d;
      extended_q <= extended_d;
      released_q <= released_d;
      kb_int_q   <= kb_int_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q     <= parity_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign kb_interrupt = kb_int_q;
  assign scancode     = scancode_q;
  assign extended     = extended_q;
  assign released     = released_q;
  assign rx_busy      = (state_q != IDLE);
`ifdef PS2_PARITY_CHECK_EN
  assign parity_err   = parity_err_q;
`endif

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench for ps2_frame_receiver: a frame-level model queues expected strobes,
// a monitor pops and compares on every kb_interrupt. Honours PS2_PARITY_CHECK_EN.
module tb_ps2_frame_receiver;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF        = 20;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_rcv = 1'b1;
  logic       ps2clk_in = 1'b1;
  logic       ps2data_in = 1'b1;
  logic       kb_interrupt;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic       rx_busy;
`ifdef PS2_PARITY_CHECK_EN
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  ps2_frame_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_rcv   (enable_rcv),
    .ps2clk_in    (ps2clk_in),
    .ps2data_in   (ps2data_in),
    .kb_interrupt (kb_interrupt),
    .scancode     (scancode),
    .extended     (extended),
    .released     (released),
`ifdef PS2_PARITY_CHECK_EN
    .parity_err   (parity_err),
`endif
    .rx_busy      (rx_busy)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic       m_ext = 1'b0;
  logic       m_rel = 1'b0;
  logic [7:0] m_code = 8'h00;
  int         exp_perr = 0;
  int         act_perr = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level reference: a good frame is either a prefix or a final code; anything dropped clears prefixes.
  task automatic model_frame(input logic [7:0] b, input bit good_stop, input bit good_par);
    bit accepted;
    accepted = good_stop && (good_par || !PAR_CHK);
    if (good_stop && !good_par && PAR_CHK) exp_perr++;
    if (!accepted) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      sb_q.push_back('{code: b, ext: m_ext, rel: m_rel});
      m_code = b;
      m_ext  = 1'b0;
      m_rel  = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit good_stop, input bit good_par,
                               input int nbits);
    logic [10:0] bits;
    logic        par;
    par  = good_par ? ~(^b) : (^b);
    bits = {good_stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2data_in = bits[i];
      wait_clks(HALF);
      ps2clk_in = 1'b0;
      wait_clks(HALF);
      ps2clk_in = 1'b1;
    end
    ps2data_in = 1'b1;
    wait_clks(2 * HALF);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good_stop, input bit good_par);
    model_frame(b, good_stop, good_par);
    applyStimulus(b, good_stop, good_par, 11);
  endtask

  task automatic check_reset_values();
    checkOutput("rst_kb_interrupt", kb_interrupt, 0);
    checkOutput("rst_scancode", scancode, 0);
    checkOutput("rst_extended", extended, 0);
    checkOutput("rst_released", released, 0);
    checkOutput("rst_rx_busy", rx_busy, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && kb_interrupt) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_strobe", kb_interrupt, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("scancode", scancode, e.code);
        checkOutput("extended", extended, e.ext);
        checkOutput("released", released, e.rel);
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  always @(negedge clk) begin
    if (!rst && parity_err) act_perr++;
  end
`endif

  initial begin
    #900000;
    $display("[TB] FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    bit   busy_seen;
    logic [7:0] b;
    wait_clks(3);
    check_reset_values();
    rst = 1'b0;
    wait_clks(20);

    send_frame(8'h1C, 1'b1, 1'b1);
    checkOutput("single_scancode", scancode, m_code);

    send_frame(8'hE0, 1'b1, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h75, 1'b1, 1'b1);
    send_frame(8'h75, 1'b1, 1'b1);

    // Short low pulse on the clock pin while data is low must not start a frame.
    ps2data_in = 1'b0;
    wait_clks(15);
    ps2clk_in = 1'b0;
    wait_clks(2);
    ps2clk_in = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rx_busy) busy_seen = 1'b1;
      wait_clks(1);
    end
    checkOutput("glitch_busy", busy_seen, 0);
    ps2data_in = 1'b1;
    wait_clks(20);

    // Abort mid-frame after a pending E0; the watchdog must drop both.
    send_frame(8'hE0, 1'b1, 1'b1);
    applyStimulus(8'h1C, 1'b1, 1'b1, 5);
    m_ext = 1'b0;
    m_rel = 1'b0;
    checkOutput("abort_busy_mid", rx_busy, 1);
    wait_clks(TIMEOUT_CYC / 2);
    checkOutput("abort_busy_before_timeout", rx_busy, 1);
    for (int i = 0; i < TIMEOUT_CYC && rx_busy; i++) wait_clks(1);
    checkOutput("timeout_release", rx_busy, 0);
    send_frame(8'h2A, 1'b1, 1'b1);

    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b0);
    checkOutput("after_bad_frames_scancode", scancode, m_code);

    // Reset in the middle of a data phase.
    applyStimulus(8'h5A, 1'b1, 1'b1, 6);
    rst = 1'b1;
    wait_clks(3);
    check_reset_values();
    rst = 1'b0;
    m_ext  = 1'b0;
    m_rel  = 1'b0;
    m_code = 8'h00;
    wait_clks(10);
    check_reset_values();
    send_frame(8'h5A, 1'b1, 1'b1);

    // Disable clears a pending prefix and ignores a whole frame.
    send_frame(8'hE0, 1'b1, 1'b1);
    enable_rcv = 1'b0;
    m_ext = 1'b0;
    m_rel = 1'b0;
    wait_clks(5);
    applyStimulus(8'h1C, 1'b1, 1'b1, 11);
    checkOutput("disabled_busy", rx_busy, 0);
    checkOutput("disabled_scancode_held", scancode, m_code);
    enable_rcv = 1'b1;
    wait_clks(10);
    send_frame(8'h29, 1'b1, 1'b1);
    checkOutput("reenable_scancode", scancode, m_code);

    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2)      b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else            b = 8'($urandom);
      send_frame(b, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
    end

    wait_clks(50);
    checkOutput("sb_drained", sb_q.size(), 0);
    checkOutput("final_scancode", scancode, m_code);
`ifdef PS2_PARITY_CHECK_EN
    checkOutput("parity_err_count", act_perr, exp_perr);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
